// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the 4 x 16-bit register file and its stream reader.
//   DATA_WIDTH  : register entry / stream data width
//   INDEX_WIDTH : register index width (NUM_REGS = 2**INDEX_WIDTH)
//   reader_state_t : readout FSM states
// ---------------------------------------------------------------------------
package regfile_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int INDEX_WIDTH = 2;
    localparam int NUM_REGS    = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } reader_state_t;
endpackage

// File: rtl/regfile_stream_reader_if.sv
// ---------------------------------------------------------------------------
// regfile_stream_reader_if
// Valid/ready output stream carrying a register value and its index.
//   out_valid / out_ready : handshake, word moves when both high at posedge
//   out_data              : register value
//   out_index             : index the value was read from
//   out_last              : final word of a readout
// master = word producer (reader), slave = consumer.
// ---------------------------------------------------------------------------
interface regfile_stream_reader_if #(
    parameter int DATA_WIDTH  = regfile_pkg::DATA_WIDTH,
    parameter int INDEX_WIDTH = regfile_pkg::INDEX_WIDTH
);
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [INDEX_WIDTH-1:0] out_index;
    logic                   out_last;

    modport master (
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_stream_reader_out_reg.sv
// ---------------------------------------------------------------------------
// stream_out_reg
// Single-entry valid/ready output register holding data, index and last.
//   clk, reset    : clock, synchronous active-low reset
//   i_load        : capture i_data/i_index/i_last (caller only loads when free)
//   i_ready       : consumer ready
//   o_free        : register can take a new word this edge
//   o_valid/o_data/o_index/o_last : registered stream outputs
// ---------------------------------------------------------------------------
module stream_out_reg #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [INDEX_WIDTH-1:0] i_index,
    input  logic                   i_last,
    input  logic                   i_ready,
    output logic                   o_free,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [INDEX_WIDTH-1:0] o_index,
    output logic                   o_last
);
    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [INDEX_WIDTH-1:0] r_index;
    logic                   r_last;

    // Empty, or the held word leaves on this edge.
    assign o_free = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_index <= i_index;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            // Data/index left as-is; only the qualifiers drop.
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_index = r_index;
    assign o_last  = r_last;
endmodule

// File: rtl/regfile_stream_reader.sv
// ---------------------------------------------------------------------------
// regfile_stream_reader
// Reads a contiguous, wrapping range of register-file entries on a start
// pulse and streams each value with its index; pulses done after the last
// word is accepted.
//   clk, reset            : clock, synchronous active-low reset
//   start                 : request readout (sampled in IDLE only)
//   first_index, count    : range start and word count (sampled with start)
//   busy, done            : status; done is a one-cycle pulse
//   rf_read_index         : registered read index to the register file
//   rf_read_data          : combinational read data from the register file
//   strm (master)         : output stream (valid/ready/data/index/last)
// ---------------------------------------------------------------------------
module regfile_stream_reader
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = regfile_pkg::DATA_WIDTH,
    parameter int INDEX_WIDTH = regfile_pkg::INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] first_index,
    input  logic [INDEX_WIDTH:0]   count,
    output logic                   busy,
    output logic                   done,
    output logic [INDEX_WIDTH-1:0] rf_read_index,
    input  logic [DATA_WIDTH-1:0]  rf_read_data,
    regfile_stream_reader_if.master strm
);
    reader_state_t          r_state, w_state_nxt;
    logic [INDEX_WIDTH-1:0] r_cur_idx, w_cur_idx_nxt;
    logic [INDEX_WIDTH:0]   r_remaining, w_remaining_nxt;
    logic                   w_free;
    logic                   w_load;
    logic                   w_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cur_idx   <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_idx   <= w_cur_idx_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_idx_nxt   = r_cur_idx;
        w_remaining_nxt = r_remaining;
        w_load          = 1'b0;
        w_last          = (r_remaining == (INDEX_WIDTH+1)'(1));
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_cur_idx_nxt   = first_index;
                        w_remaining_nxt = count;
                        w_state_nxt     = FETCH;
                    end else begin
                        w_state_nxt = FINISH;
                    end
                end
            end
            FETCH: begin
                if (w_free) begin
                    w_load          = 1'b1;
                    // Natural width overflow gives the 3 -> 0 wrap.
                    w_cur_idx_nxt   = r_cur_idx + INDEX_WIDTH'(1);
                    w_remaining_nxt = r_remaining - (INDEX_WIDTH+1)'(1);
                    if (w_last) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (strm.out_valid && strm.out_ready) w_state_nxt = FINISH;
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read index comes straight from the cur_idx register, so the register
    // file sees no combinational path from this block's inputs.
    assign rf_read_index = r_cur_idx;
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == FINISH);

    stream_out_reg #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_data  (rf_read_data),
        .i_index (r_cur_idx),
        .i_last  (w_last),
        .i_ready (strm.out_ready),
        .o_free  (w_free),
        .o_valid (strm.out_valid),
        .o_data  (strm.out_data),
        .o_index (strm.out_index),
        .o_last  (strm.out_last)
    );
endmodule

// File: tb/tb_regfile_stream_reader.sv
module tb_regfile_stream_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  first_index = '0;
    logic [2:0]  count = '0;
    logic        busy, done;
    logic [1:0]  rf_read_index;
    logic [15:0] rf_read_data;

    // Register file write port (bench side)
    logic        we = 1'b0;
    logic [1:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] mem [4];
    logic [15:0] shadow [4];

    int errors = 0;
    int checks = 0;

    regfile_stream_reader_if #(.DATA_WIDTH(16), .INDEX_WIDTH(2)) strm ();

    regfile_stream_reader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .first_index   (first_index),
        .count         (count),
        .busy          (busy),
        .done          (done),
        .rf_read_index (rf_read_index),
        .rf_read_data  (rf_read_data),
        .strm          (strm)
    );

    always #5 clk = ~clk;

    assign rf_read_data = mem[rf_read_index];
    always @(posedge clk) if (we) mem[waddr] <= wdata;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick;
        we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        strm.out_ready = 1'b1;
        wr(2'd0, 16'h1111);
        wr(2'd1, 16'h2222);
        wr(2'd2, 16'h3333);
        wr(2'd3, 16'h4444);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (strm.out_valid !== 1'b0 || strm.out_last !== 1'b0) begin errors++; $display("FAIL reset_valid_last: got %b%b exp 00", strm.out_valid, strm.out_last); end
        checks++; if (strm.out_data !== 16'h0 || strm.out_index !== 2'd0) begin errors++; $display("FAIL reset_data_index: got %h/%0d exp 0000/0", strm.out_data, strm.out_index); end
        checks++; if (rf_read_index !== 2'd0) begin errors++; $display("FAIL reset_rf_index: got %0d exp 0", rf_read_index); end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_linear;
        logic [15:0] ed [4];
        ed = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        strm.out_ready = 1'b1; first_index = 2'd0; count = 3'd4; start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || strm.out_valid !== 1'b0) begin errors++; $display("FAIL linear_start: busy/valid got %b%b exp 10", busy, strm.out_valid); end
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if ({strm.out_valid, strm.out_data, strm.out_index, strm.out_last} !== {1'b1, ed[k], 2'(k), (k == 3)}) begin
                errors++;
                $display("FAIL linear_word%0d: got v=%b %h/%0d l=%b exp v=1 %h/%0d l=%b", k, strm.out_valid, strm.out_data, strm.out_index, strm.out_last, ed[k], k, (k == 3));
            end
        end
        tick;
        checks++; if (done !== 1'b1 || strm.out_valid !== 1'b0) begin errors++; $display("FAIL linear_done: done/valid got %b%b exp 10", done, strm.out_valid); end
        tick;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL linear_idle: done/busy got %b%b exp 00", done, busy); end
    endtask

    task automatic test_wrap;
        logic [15:0] ed [3];
        logic [1:0]  ei [3];
        ed = '{16'h4444, 16'h1111, 16'h2222};
        ei = '{2'd3, 2'd0, 2'd1};
        strm.out_ready = 1'b1; first_index = 2'd3; count = 3'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if ({strm.out_valid, strm.out_data, strm.out_index, strm.out_last} !== {1'b1, ed[k], ei[k], (k == 2)}) begin
                errors++;
                $display("FAIL wrap_word%0d: got v=%b %h/%0d l=%b exp v=1 %h/%0d l=%b", k, strm.out_valid, strm.out_data, strm.out_index, strm.out_last, ed[k], ei[k], (k == 2));
            end
        end
        tick;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b exp 1", done); end
        tick;
    endtask

    task automatic test_stall;
        logic        pat [4];
        logic [15:0] ed [4];
        logic [15:0] sd;
        logic [1:0]  si;
        logic        stalled;
        logic        seen_done;
        int          hs;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ed  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        stalled = 1'b0; seen_done = 1'b0; hs = 0; sd = '0; si = '0;
        strm.out_ready = 1'b1; first_index = 2'd0; count = 3'd4; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            strm.out_ready = pat[c % 4];
            if (stalled) begin
                checks++;
                if (strm.out_valid !== 1'b1 || strm.out_data !== sd || strm.out_index !== si) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h/%0d exp v=1 %h/%0d", strm.out_valid, strm.out_data, strm.out_index, sd, si);
                end
            end
            stalled = 1'b0;
            if (strm.out_valid === 1'b1) begin
                if (strm.out_ready) begin
                    checks++;
                    if (hs >= 4 || strm.out_data !== ed[hs % 4] || strm.out_index !== 2'(hs) || strm.out_last !== (hs == 3)) begin
                        errors++;
                        $display("FAIL stall_word%0d: got %h/%0d l=%b exp %h/%0d l=%b", hs, strm.out_data, strm.out_index, strm.out_last, ed[hs % 4], hs, (hs == 3));
                    end
                    hs++;
                end else begin
                    stalled = 1'b1; sd = strm.out_data; si = strm.out_index;
                end
            end
            tick;
            if (done === 1'b1) seen_done = 1'b1;
        end
        checks++; if (hs != 4 || !seen_done) begin errors++; $display("FAIL stall_count: handshakes=%0d done=%b exp 4/1", hs, seen_done); end
        strm.out_ready = 1'b1;
        tick;
    endtask

    task automatic test_zero_count;
        strm.out_ready = 1'b1; first_index = 2'd1; count = 3'd0; start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if ({done, busy, strm.out_valid} !== 3'b110) begin errors++; $display("FAIL zero_done: done/busy/valid got %b%b%b exp 110", done, busy, strm.out_valid); end
        tick;
        checks++; if ({done, busy, strm.out_valid} !== 3'b000) begin errors++; $display("FAIL zero_idle: done/busy/valid got %b%b%b exp 000", done, busy, strm.out_valid); end
    endtask

    task automatic test_mid_reset;
        logic saw_done;
        saw_done = 1'b0;
        strm.out_ready = 1'b1; first_index = 2'd0; count = 3'd4; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        checks++; if (strm.out_valid !== 1'b1 || strm.out_index !== 2'd1) begin errors++; $display("FAIL midrst_pre: got v=%b idx=%0d exp v=1 idx=1", strm.out_valid, strm.out_index); end
        reset = 1'b0;
        tick;
        reset = 1'b1;
        checks++; if ({strm.out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL midrst_clear: valid/busy/done got %b%b%b exp 000", strm.out_valid, busy, done); end
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1 || strm.out_valid === 1'b1) saw_done = 1'b1;
            tick;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_quiet: activity after reset got 1 exp 0"); end
    endtask

    task automatic test_restart;
        strm.out_ready = 1'b1; first_index = 2'd2; count = 3'd2; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        checks++; if ({strm.out_valid, strm.out_data, strm.out_index, strm.out_last} !== {1'b1, 16'h3333, 2'd2, 1'b0}) begin errors++; $display("FAIL restart_w0: got %h/%0d l=%b exp 3333/2 l=0", strm.out_data, strm.out_index, strm.out_last); end
        tick;
        checks++; if ({strm.out_valid, strm.out_data, strm.out_index, strm.out_last} !== {1'b1, 16'h4444, 2'd3, 1'b1}) begin errors++; $display("FAIL restart_w1: got %h/%0d l=%b exp 4444/3 l=1", strm.out_data, strm.out_index, strm.out_last); end
        tick;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b exp 1", done); end
        tick;
    endtask

    task automatic test_repulse;
        strm.out_ready = 1'b1; first_index = 2'd0; count = 3'd2; start = 1'b1;
        tick;
        first_index = 2'd3; count = 3'd5;   // start stays high while busy
        tick;
        checks++; if ({strm.out_data, strm.out_index, strm.out_last} !== {16'h1111, 2'd0, 1'b0}) begin errors++; $display("FAIL repulse_w0: got %h/%0d l=%b exp 1111/0 l=0", strm.out_data, strm.out_index, strm.out_last); end
        tick;
        checks++; if ({strm.out_data, strm.out_index, strm.out_last} !== {16'h2222, 2'd1, 1'b1}) begin errors++; $display("FAIL repulse_w1: got %h/%0d l=%b exp 2222/1 l=1", strm.out_data, strm.out_index, strm.out_last); end
        tick;
        checks++; if (done !== 1'b1 || strm.out_valid !== 1'b0) begin errors++; $display("FAIL repulse_done: done/valid got %b%b exp 10", done, strm.out_valid); end
        start = 1'b0;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL repulse_idle: busy got %b exp 0", busy); end
    endtask

    task automatic test_collision;
        strm.out_ready = 1'b1; first_index = 2'd2; count = 3'd1; start = 1'b1;
        tick;
        start = 1'b0;
        we = 1'b1; waddr = 2'd2; wdata = 16'hBEEF;   // lands on the capture edge
        tick;
        we = 1'b0;
        shadow[2] = 16'hBEEF;
        checks++; if ({strm.out_valid, strm.out_data, strm.out_last} !== {1'b1, 16'h3333, 1'b1}) begin errors++; $display("FAIL collide_old: got v=%b %h l=%b exp v=1 3333 l=1", strm.out_valid, strm.out_data, strm.out_last); end
        tick;
        tick;
        first_index = 2'd2; count = 3'd1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        checks++; if ({strm.out_valid, strm.out_data, strm.out_index} !== {1'b1, 16'hBEEF, 2'd2}) begin errors++; $display("FAIL collide_new: got v=%b %h/%0d exp v=1 beef/2", strm.out_valid, strm.out_data, strm.out_index); end
        tick;
        tick;
    endtask

    task automatic test_random;
        logic [1:0] f;
        logic [2:0] n;
        logic       seen_done;
        int         k;
        for (int b = 0; b < 8; b++) begin
            wr(2'($urandom_range(0, 3)), 16'($urandom));
            f = (b == 0) ? 2'd1 : 2'($urandom_range(0, 3));
            n = (b == 0) ? 3'd7 : 3'($urandom_range(1, 7));
            k = 0; seen_done = 1'b0;
            first_index = f; count = n; start = 1'b1;
            tick;
            start = 1'b0;
            for (int c = 0; c < 80 && !seen_done; c++) begin
                strm.out_ready = 1'($urandom_range(0, 1));
                if (strm.out_valid === 1'b1 && strm.out_ready) begin
                    checks++;
                    if (strm.out_index !== 2'(f + 2'(k)) || strm.out_data !== shadow[2'(f + 2'(k))] || strm.out_last !== (k == int'(n) - 1)) begin
                        errors++;
                        $display("FAIL rand_b%0d_w%0d: got %h/%0d l=%b exp %h/%0d l=%b", b, k, strm.out_data, strm.out_index, strm.out_last, shadow[2'(f + 2'(k))], 2'(f + 2'(k)), (k == int'(n) - 1));
                    end
                    k++;
                end
                tick;
                if (done === 1'b1) seen_done = 1'b1;
            end
            checks++; if (k != int'(n) || !seen_done) begin errors++; $display("FAIL rand_b%0d_count: words=%0d done=%b exp %0d/1", b, k, seen_done, n); end
            strm.out_ready = 1'b1;
            tick;
        end
    endtask

    initial begin
        strm.out_ready = 1'b1;
        test_reset;
        test_linear;
        test_wrap;
        test_stall;
        test_zero_count;
        test_mid_reset;
        test_restart;
        test_repulse;
        test_collision;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
